sdrstick_rx_packer: RTL and testbench

//  Multi-channel successor to the single-receiver sample mover. Captures NUM_CH parallel
//  I/Q sample pairs on a shared strobe, serialises enabled channels as 32-bit words
//  (I then Q, ascending channel), writes them to the CPU-side FIFO with backpressure.

---
 rtl/sdrstick_rx_packer_if.sv | 31 +++
 rtl/sdrstick_rx_packer.sv | 191 +++++++++++++++++++
 tb/tb_sdrstick_rx_packer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdrstick_rx_packer_if.sv
// Bus bundle for sdrstick_rx_packer: sample capture inputs, CPU-side FIFO
// write port and the CPU control/status register port.
// master = the environment (sample source, FIFO, CPU); slave = the packer.
interface sdrstick_rx_packer_if #(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 24
);
    logic                         in_strobe;
    logic [NUM_CH*SAMPLE_W-1:0]   in_i;
    logic [NUM_CH*SAMPLE_W-1:0]   in_q;
    logic                         fifo_full;
    logic                         fifo_write;
    logic [31:0]                  fifo_writedata;
    logic [2:0]                   ctl_address;
    logic                         ctl_read;
    logic [31:0]                  ctl_readdata;
    logic                         ctl_write;
    logic [31:0]                  ctl_writedata;

    modport master (
        output in_strobe, in_i, in_q, fifo_full,
        output ctl_address, ctl_read, ctl_write, ctl_writedata,
        input  fifo_write, fifo_writedata, ctl_readdata
    );

    modport slave (
        input  in_strobe, in_i, in_q, fifo_full,
        input  ctl_address, ctl_read, ctl_write, ctl_writedata,
        output fifo_write, fifo_writedata, ctl_readdata
    );
endinterface

// File: rtl/sdrstick_rx_packer.sv
// sdrstick_rx_packer: captures NUM_CH I/Q sample pairs on a strobe and writes
// the enabled channels to the CPU FIFO as 32-bit words (I then Q, ascending
// channel), honouring fifo_full backpressure. Strobes arriving mid-frame are
// dropped and counted in a saturating overrun counter.
// Optional feature macro: SDRSTICK_RX_SAMPLE_TAG_EN -- when defined each word
// carries {iq, ch[2:0], seq[3:0]} above a 24-bit sign-extended sample;
// otherwise the sample is sign-extended to the full 32 bits.
module sdrstick_rx_packer #(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 24
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sdrstick_rx_packer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WRITE_I, WRITE_Q} state_t;

    state_t                       r_state, w_state_next;
    logic                         r_enable, w_enable_next;
    logic [NUM_CH-1:0]            r_mask, w_mask_next;
    logic [NUM_CH-1:0]            r_frame_mask;
    logic [NUM_CH*SAMPLE_W-1:0]   r_hold_i, r_hold_q;
    logic [2:0]                   r_ch, w_ch_next;
    logic [15:0]                  r_overrun, w_overrun_next;
    logic                         r_fifo_write, w_fifo_write_next;
    logic [31:0]                  r_fifo_writedata, w_fifo_writedata_next;
    logic [31:0]                  r_readdata, w_readdata_next;
    logic                         w_accept, w_overrun_inc;
    logic [2:0]                   w_first_ch, w_next_ch;
    logic                         w_next_found;
    logic [SAMPLE_W-1:0]          w_sel_i, w_sel_q;
    logic signed [SAMPLE_W-1:0]   w_sample;
    logic                         w_is_q;
    logic [31:0]                  w_word;

    // Channel scan: lowest enabled channel for a new frame, and the next
    // enabled channel above the current one within the latched frame mask.
    always_comb begin
        w_first_ch   = 3'd0;
        w_next_ch    = 3'd0;
        w_next_found = 1'b0;
        w_sel_i      = '0;
        w_sel_q      = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (r_mask[k]) w_first_ch = 3'(k);
            if (r_frame_mask[k] && (3'(k) > r_ch)) begin
                w_next_found = 1'b1;
                w_next_ch    = 3'(k);
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_ch == 3'(k)) begin
                w_sel_i = r_hold_i[k*SAMPLE_W +: SAMPLE_W];
                w_sel_q = r_hold_q[k*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    assign w_is_q   = (r_state == WRITE_Q);
    assign w_sample = w_is_q ? w_sel_q : w_sel_i;

`ifdef SDRSTICK_RX_SAMPLE_TAG_EN
    logic [3:0] r_seq, r_frame_seq;

    // Frame sequence counter; each frame is tagged with the count at acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seq       <= 4'd0;
            r_frame_seq <= 4'd0;
        end else if (w_accept) begin
            r_frame_seq <= r_seq;
            r_seq       <= r_seq + 4'd1;
        end
    end

    assign w_word = {w_is_q, r_ch, r_frame_seq, 24'(w_sample)};
`else
    assign w_word = 32'(w_sample);
`endif

    // Frame FSM next-state and FIFO write generation.
    always_comb begin
        w_state_next          = r_state;
        w_ch_next             = r_ch;
        w_fifo_write_next     = 1'b0;
        w_fifo_writedata_next = r_fifo_writedata;
        w_accept              = 1'b0;
        w_overrun_inc         = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.in_strobe && r_enable && (|r_mask)) begin
                    w_accept     = 1'b1;
                    w_ch_next    = w_first_ch;
                    w_state_next = WRITE_I;
                end
            end
            WRITE_I, WRITE_Q: begin
                w_overrun_inc = bus.in_strobe && r_enable;
                if (!bus.fifo_full) begin
                    w_fifo_write_next     = 1'b1;
                    w_fifo_writedata_next = w_word;
                    if (r_state == WRITE_I) begin
                        w_state_next = WRITE_Q;
                    end else if (w_next_found) begin
                        w_ch_next    = w_next_ch;
                        w_state_next = WRITE_I;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Register file: a write in the same cycle as a read is visible in the
    // read data; a clear write overrides a simultaneous overrun increment.
    always_comb begin
        w_enable_next  = r_enable;
        w_mask_next    = r_mask;
        w_overrun_next = r_overrun;
        if (w_overrun_inc && (r_overrun != 16'hFFFF)) begin
            w_overrun_next = r_overrun + 16'd1;
        end
        if (bus.ctl_write) begin
            case (bus.ctl_address)
                3'd0: begin
                    w_enable_next = bus.ctl_writedata[0];
                    w_mask_next   = bus.ctl_writedata[8 +: NUM_CH];
                end
                3'd2:    w_overrun_next = 16'd0;
                default: ;
            endcase
        end
        w_readdata_next = r_readdata;
        if (bus.ctl_read) begin
            w_readdata_next = '0;
            case (bus.ctl_address)
                3'd0: begin
                    w_readdata_next[0]           = w_enable_next;
                    w_readdata_next[8 +: NUM_CH] = w_mask_next;
                end
                3'd1: begin
                    w_readdata_next[15:0] = w_overrun_next;
                    w_readdata_next[16]   = (w_state_next != IDLE);
                end
                default: ;
            endcase
        end
    end

    // State register for FSM, control registers, counters and outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= IDLE;
            r_ch             <= 3'd0;
            r_enable         <= 1'b0;
            r_mask           <= '0;
            r_frame_mask     <= '0;
            r_overrun        <= 16'd0;
            r_fifo_write     <= 1'b0;
            r_fifo_writedata <= 32'd0;
            r_readdata       <= 32'd0;
        end else begin
            r_state          <= w_state_next;
            r_ch             <= w_ch_next;
            r_enable         <= w_enable_next;
            r_mask           <= w_mask_next;
            r_overrun        <= w_overrun_next;
            r_fifo_write     <= w_fifo_write_next;
            r_fifo_writedata <= w_fifo_writedata_next;
            r_readdata       <= w_readdata_next;
            if (w_accept) r_frame_mask <= r_mask;
        end
    end

    // Holding registers: snapshot of all channels at frame acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_i <= '0;
            r_hold_q <= '0;
        end else if (w_accept) begin
            r_hold_i <= bus.in_i;
            r_hold_q <= bus.in_q;
        end
    end

    assign bus.fifo_write     = r_fifo_write;
    assign bus.fifo_writedata = r_fifo_writedata;
    assign bus.ctl_readdata   = r_readdata;
endmodule

// File: tb/tb_sdrstick_rx_packer.sv
// Testbench for sdrstick_rx_packer (NUM_CH=2, SAMPLE_W=24). Works for both the
// default build and the SDRSTICK_RX_SAMPLE_TAG_EN build.
module tb_sdrstick_rx_packer;
    localparam int NUM_CH = 2;
    localparam int SW     = 24;
    localparam int BW     = NUM_CH * SW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    sdrstick_rx_packer_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SW)) bus ();

    sdrstick_rx_packer #(.NUM_CH(NUM_CH), .SAMPLE_W(SW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit seen    = 1'b0;

    // Reference model state
    logic [31:0]       m_frame[$];
    logic              m_enable = 1'b0;
    logic [NUM_CH-1:0] m_mask   = '0;
    int                m_ovf    = 0;
    int                m_seq    = 0;
    logic              exp_fw   = 1'b0;
    logic [31:0]       exp_fd   = '0;
    logic              rd_chk   = 1'b0;
    logic [31:0]       exp_rd   = '0;

    int          log_cyc[$];
    logic [31:0] log_dat[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] mk_word(input bit iq, input int ch, input int seq, input logic [23:0] s);
`ifdef SDRSTICK_RX_SAMPLE_TAG_EN
        return {iq, 3'(ch), 4'(seq), s};
`else
        return {{8{s[23]}}, s};
`endif
    endfunction

    always @(posedge clk) begin
        cyc++;
        seen = 1'b1;
    end

    // Behavioural model: a frame is a queue of words; one word leaves per
    // cycle the FIFO is not full; strobes while words remain are overruns.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_frame.delete();
            m_enable = 1'b0; m_mask = '0; m_ovf = 0; m_seq = 0;
            exp_fw = 1'b0; exp_fd = '0; rd_chk = 1'b0; exp_rd = '0;
        end else begin
            bit inc;
            inc    = 1'b0;
            exp_fw = 1'b0;
            if (m_frame.size() != 0) begin
                if (bus.in_strobe && m_enable) inc = 1'b1;
                if (!bus.fifo_full) begin
                    exp_fw = 1'b1;
                    exp_fd = m_frame.pop_front();
                end
            end else if (bus.in_strobe && m_enable && m_mask != 0) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (m_mask[k]) begin
                        m_frame.push_back(mk_word(1'b0, k, m_seq, bus.in_i[k*SW +: SW]));
                        m_frame.push_back(mk_word(1'b1, k, m_seq, bus.in_q[k*SW +: SW]));
                    end
                end
                m_seq = (m_seq + 1) % 16;
            end
            if (inc && m_ovf < 65535) m_ovf++;
            if (bus.ctl_write) begin
                if (bus.ctl_address == 3'd0) begin
                    m_enable = bus.ctl_writedata[0];
                    m_mask   = bus.ctl_writedata[8 +: NUM_CH];
                end else if (bus.ctl_address == 3'd2) begin
                    m_ovf = 0;
                end
            end
            rd_chk = bus.ctl_read;
            if (bus.ctl_read) begin
                exp_rd = '0;
                if (bus.ctl_address == 3'd0) begin
                    exp_rd[0]           = m_enable;
                    exp_rd[8 +: NUM_CH] = m_mask;
                end else if (bus.ctl_address == 3'd1) begin
                    exp_rd[15:0] = 16'(m_ovf);
                    exp_rd[16]   = (m_frame.size() != 0);
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus a log of all FIFO writes.
    always @(negedge clk) begin
        if (seen) begin
            check("fifo_write", 32'(bus.fifo_write), 32'(exp_fw));
            if (exp_fw) check("fifo_writedata", bus.fifo_writedata, exp_fd);
            if (rd_chk && reset_n) check("ctl_readdata", bus.ctl_readdata, exp_rd);
            if (bus.fifo_write) begin
                log_cyc.push_back(cyc);
                log_dat.push_back(bus.fifo_writedata);
                $display("cycle %0d: fifo write %h", cyc, bus.fifo_writedata);
            end
        end
    end

    task automatic next_cyc();
        @(negedge clk);
        #1;
        bus.in_strobe = 1'b0;
        bus.ctl_write = 1'b0;
        bus.ctl_read  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) next_cyc();
    endtask

    task automatic ctl_wr(input logic [2:0] a, input logic [31:0] d);
        next_cyc();
        bus.ctl_address = a; bus.ctl_writedata = d; bus.ctl_write = 1'b1;
    endtask

    task automatic rd_expect(input logic [2:0] a, input logic [31:0] exp, input string name);
        next_cyc();
        bus.ctl_address = a; bus.ctl_read = 1'b1;
        next_cyc();
        check(name, bus.ctl_readdata, exp);
        $display("read addr %0d -> %h", a, bus.ctl_readdata);
    endtask

    task automatic strobe4(input logic [23:0] i0, input logic [23:0] q0,
                           input logic [23:0] i1, input logic [23:0] q1, output int n);
        next_cyc();
        bus.in_i = {i1, i0}; bus.in_q = {q1, q0}; bus.in_strobe = 1'b1;
        n = cyc;
    endtask

    logic [31:0] t2_exp[4];
    logic [7:0]  t3_qtop, t9_itop, t9_qtop;

    initial begin
        int n, s;
        bus.in_strobe = 0; bus.in_i = '0; bus.in_q = '0; bus.fifo_full = 0;
        bus.ctl_address = 0; bus.ctl_read = 0; bus.ctl_write = 0; bus.ctl_writedata = 0;
`ifdef SDRSTICK_RX_SAMPLE_TAG_EN
        t2_exp[0] = 32'h00000123; t2_exp[1] = 32'h80FFFFFE;
        t2_exp[2] = 32'h10000001; t2_exp[3] = 32'h90000002;
        t3_qtop = 8'h91; t9_itop = 8'h10; t9_qtop = 8'h90;
`else
        t2_exp[0] = 32'h00000123; t2_exp[1] = 32'hFFFFFFFE;
        t2_exp[2] = 32'h00000001; t2_exp[3] = 32'h00000002;
        t3_qtop = 8'hFF; t9_itop = 8'h00; t9_qtop = 8'h00;
`endif
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        check("rst_fifo_write", 32'(bus.fifo_write), 32'd0);
        rd_expect(3'd0, 32'h0, "rst_ctrl");
        rd_expect(3'd1, 32'h0, "rst_status");

        // Both channels, first frame, exact latency and words
        ctl_wr(3'd0, 32'h0000_0301);
        s = log_dat.size();
        strobe4(24'h000123, 24'hFFFFFE, 24'h000001, 24'h000002, n);
        idle(8);
        check("t2_count", 32'(log_dat.size() - s), 32'd4);
        for (int j = 0; j < 4; j++) begin
            if (s + j < log_dat.size()) begin
                check("t2_cycle", 32'(log_cyc[s+j]), 32'(n + 2 + j));
                check("t2_word", log_dat[s+j], t2_exp[j]);
            end
        end
        rd_expect(3'd0, 32'h0000_0301, "t2_ctrl");

        // Channel 1 only, most-negative Q sample
        ctl_wr(3'd0, 32'h0000_0201);
        s = log_dat.size();
        strobe4(24'h111111, 24'h222222, 24'h0ABCDE, 24'h800000, n);
        idle(8);
        check("t3_count", 32'(log_dat.size() - s), 32'd2);
        if (log_dat.size() >= s + 2) begin
            check("t3_i_low", 32'(log_dat[s][23:0]), 32'h0ABCDE);
            check("t3_q_low", 32'(log_dat[s+1][23:0]), 32'h800000);
            check("t3_q_top", 32'(log_dat[s+1][31:24]), 32'(t3_qtop));
        end

        // Disabled: strobe ignored and not counted
        ctl_wr(3'd0, 32'h0000_0300);
        s = log_dat.size();
        strobe4(24'h1, 24'h2, 24'h3, 24'h4, n);
        idle(6);
        check("t4_count", 32'(log_dat.size() - s), 32'd0);
        rd_expect(3'd1, 32'h0, "t4_status");

        // Backpressure: fifo_full high for cycles N+1..N+10
        ctl_wr(3'd0, 32'h0000_0301);
        s = log_dat.size();
        strobe4(24'h0000A0, 24'h0000A1, 24'h0000B0, 24'h0000B1, n);
        next_cyc(); bus.fifo_full = 1'b1;
        idle(9);
        next_cyc(); bus.fifo_full = 1'b0;
        idle(8);
        check("t5_count", 32'(log_dat.size() - s), 32'd4);
        for (int j = 0; j < 4; j++) begin
            if (s + j < log_dat.size()) begin
                check("t5_cycle", 32'(log_cyc[s+j]), 32'(n + 12 + j));
                check("t5_low", 32'(log_dat[s+j][23:0]), 32'h0000A0 + 32'((j / 2) * 16 + (j % 2)));
            end
        end

        // Overrun: second strobe at N+3 is dropped and counted
        s = log_dat.size();
        strobe4(24'h5, 24'h6, 24'h7, 24'h8, n);
        idle(2);
        next_cyc(); bus.in_strobe = 1'b1;
        idle(8);
        check("t6_count", 32'(log_dat.size() - s), 32'd4);
        rd_expect(3'd1, 32'h0000_0001, "t6_overrun");

        // Saturation, clear-wins and clear
        s = log_dat.size();
        strobe4(24'h9, 24'hA, 24'hB, 24'hC, n);
        bus.fifo_full = 1'b1;
        repeat (70000) begin
            next_cyc(); bus.in_strobe = 1'b1;
        end
        rd_expect(3'd1, 32'h0001_FFFF, "t7_saturate");
        next_cyc(); bus.in_strobe = 1'b1;
        bus.ctl_address = 3'd2; bus.ctl_write = 1'b1;
        rd_expect(3'd1, 32'h0001_0000, "t7_clear_wins");
        next_cyc(); bus.in_strobe = 1'b1;
        rd_expect(3'd1, 32'h0001_0001, "t7_count_again");
        ctl_wr(3'd2, 32'h0);
        rd_expect(3'd1, 32'h0001_0000, "t7_cleared");
        next_cyc(); bus.fifo_full = 1'b0;
        idle(10);
        check("t7_count", 32'(log_dat.size() - s), 32'd4);
        rd_expect(3'd1, 32'h0, "t7_idle");

        // Asynchronous reset mid-frame after the second word
        s = log_dat.size();
        strobe4(24'h10, 24'h11, 24'h12, 24'h13, n);
        for (int t = 0; t < 20 && log_dat.size() < s + 2; t++) next_cyc();
        check("t8_two_words", 32'(log_dat.size() >= s + 2), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t8_rst_fifo_write", 32'(bus.fifo_write), 32'd0);
        idle(2);
        reset_n = 1'b1;
        rd_expect(3'd1, 32'h0, "t8_status");
        rd_expect(3'd0, 32'h0, "t8_ctrl");

        // 17 frames on channel 1: sequence tag wraps
        ctl_wr(3'd0, 32'h0000_0201);
        for (int f = 1; f <= 17; f++) begin
            strobe4(24'h0, 24'h0, 24'(f), 24'(256 + f), n);
            idle(5);
        end
        s = log_dat.size();
        if (s >= 2) begin
            check("t9_i_top", 32'(log_dat[s-2][31:24]), 32'(t9_itop));
            check("t9_q_top", 32'(log_dat[s-1][31:24]), 32'(t9_qtop));
            check("t9_i_low", 32'(log_dat[s-2][23:0]), 32'h11);
            check("t9_q_low", 32'(log_dat[s-1][23:0]), 32'h111);
        end

        // Randomised traffic against the model
        for (int t = 0; t < 3000; t++) begin
            next_cyc();
            bus.in_i      = BW'({$urandom(), $urandom()});
            bus.in_q      = BW'({$urandom(), $urandom()});
            bus.in_strobe = ($urandom_range(0, 5) == 0);
            bus.fifo_full = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) begin
                bus.ctl_address      = 3'($urandom_range(0, 3));
                bus.ctl_writedata    = $urandom();
                bus.ctl_writedata[0] = ($urandom_range(0, 3) != 0);
                bus.ctl_write        = 1'b1;
            end else if ($urandom_range(0, 4) == 0) begin
                bus.ctl_address = 3'($urandom_range(0, 7));
                bus.ctl_read    = 1'b1;
            end
        end
        next_cyc(); bus.fifo_full = 1'b0;
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
